// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, two write ports, and a
// sequenced full-array clear. Define REGFILE_BYPASS_EN for same-edge write-to-read forwarding.
module regfile_mp #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned ADDR_W   = $clog2(DEPTH),
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   output logic [NUM_RD-1:0]        rvalid,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        waddr0,
   input  logic [DATA_W-1:0]        wdata0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        waddr1,
   input  logic [DATA_W-1:0]        wdata1,
   input  logic                     clr_req,
   output logic                     busy
);

   localparam bit ZeroOn = (ZERO_REG != 0);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   state_e                    state_q;
   logic [ADDR_W-1:0]         clr_ptr_q;
   logic [DATA_W-1:0]         mem [DEPTH];
   logic [NUM_RD*DATA_W-1:0]  rdata_q;
   logic [NUM_RD-1:0]         rvalid_q;
   logic                      wr0_ok;
   logic                      wr1_ok;
   logic [DATA_W-1:0]         rd_val [NUM_RD];

   assign busy   = (state_q == StClear);
   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StClear;
         clr_ptr_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (clr_req) begin
                  state_q   <= StClear;
                  clr_ptr_q <= '0;
               end
            end
            StClear: begin
               if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                  state_q   <= StIdle;
                  clr_ptr_q <= '0;
               end else begin
                  clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Port 1 wins a same-address collision, so port 0 is suppressed rather than overwritten.
   always_comb begin
      wr0_ok = we0 && !busy && !(ZeroOn && (waddr0 == '0)) && !(we1 && (waddr1 == waddr0));
      wr1_ok = we1 && !busy && !(ZeroOn && (waddr1 == '0));
   end

   // Storage has no reset; the clear sequencer is the only initialiser.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (busy) begin
            mem[clr_ptr_q] <= '0;
         end else begin
            if (wr0_ok) mem[waddr0] <= wdata0;
            if (wr1_ok) mem[waddr1] <= wdata1;
         end
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         rd_val[p] = mem[raddr[p*ADDR_W +: ADDR_W]];
         if (ZeroOn && (raddr[p*ADDR_W +: ADDR_W] == '0)) begin
            rd_val[p] = '0;
`ifdef REGFILE_BYPASS_EN
         end else if (wr1_ok && (waddr1 == raddr[p*ADDR_W +: ADDR_W])) begin
            rd_val[p] = wdata1;
         end else if (wr0_ok && (waddr0 == raddr[p*ADDR_W +: ADDR_W])) begin
            rd_val[p] = wdata0;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q  <= '0;
         rvalid_q <= '0;
      end else begin
         for (int p = 0; p < NUM_RD; p++) begin
            rvalid_q[p] <= rd_en[p] && !busy;
            if (rd_en[p] && !busy) rdata_q[p*DATA_W +: DATA_W] <= rd_val[p];
         end
      end
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of each entry in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of entries (power of two, 4 to 256).
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), meaning width of each address.
REQ-004 SHALL have parameter NUM_RD, default 2, meaning number of read ports (1 to 4).
REQ-005 SHALL have parameter ZERO_REG, default 1; when 1, entry 0 is hardwired to zero.
REQ-006 Ports, in this order:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- rd_en  in  NUM_RD  per-port read enable.
- raddr  in  NUM_RD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  read data; port p occupies bits [p*DATA_W +: DATA_W].
- rvalid  out  NUM_RD  per-port read-data-valid pulse.
- we0, waddr0, wdata0  in  1/ADDR_W/DATA_W  write port 0.
- we1, waddr1, wdata1  in  1/ADDR_W/DATA_W  write port 1.
- clr_req  in  1  request a full array clear.
- busy  out  1  high while the clear sequencer is active.

Function
REQ-007 Reads SHALL be registered with 1-cycle latency: if rd_en[p] is high at edge N, rdata[p] shows the entry at raddr[p] and rvalid[p]=1 after edge N.
REQ-008 If rd_en[p] is low, rdata[p] SHALL hold its previous value and rvalid[p] SHALL be 0.
REQ-009 A write with weK=1 SHALL update the entry at waddrK at the rising edge.
REQ-010 If we0 and we1 are both high and waddr0==waddr1, the write SHALL take wdata1; port 0 is dropped.
REQ-011 If ZERO_REG=1, writes to address 0 SHALL be ignored and reads of address 0 SHALL return 0.
REQ-012 Clear FSM states: IDLE, CLEAR.
- IDLE -> CLEAR on clr_req=1.
- CLEAR writes 0 to entry clr_ptr each cycle, clr_ptr incrementing from 0.
- CLEAR -> IDLE after clr_ptr==DEPTH-1 is written, so CLEAR lasts exactly DEPTH cycles.
REQ-013 busy SHALL equal 1 exactly while the FSM is in CLEAR.
REQ-014 While busy=1:
- we0, we1 and rd_en SHALL be ignored.
- rvalid SHALL be 0.
- rdata SHALL hold its value.
REQ-015 clr_req during CLEAR SHALL be ignored; the sequence does not restart.
REQ-016 clr_req and a write in the same IDLE cycle: the write SHALL complete, and clearing begins the next cycle.
REQ-017 A read of entry A in the cycle following a write to A SHALL return the new data.

Reset
REQ-018 reset=1 at an edge SHALL force FSM=CLEAR, clr_ptr=0, rdata=0, rvalid=0 and busy=1.
REQ-019 After reset deasserts, the array SHALL be all-zero and busy SHALL be 0 after exactly DEPTH cycles.
REQ-020 reset asserted mid-CLEAR SHALL restart the clear from clr_ptr=0.
REQ-021 Array storage SHALL NOT be reset directly; it is initialised only by the clear sequencer.

Configuration
REQ-022 The macro REGFILE_BYPASS_EN SHALL enable same-cycle write-to-read forwarding.
- Defined: if rd_en[p] and raddr[p] match an active write at the same edge, rdata[p] SHALL return the write data. Port 1 data takes priority. Address 0 is excluded when ZERO_REG=1.
- Undefined: rdata[p] SHALL return the pre-write array contents.

Verification
REQ-023 Reset release, DEPTH=32 -> busy=1 for exactly 32 cycles, then 0; a read of every address returns 0x00000000.
REQ-024 Write 0xDEADBEEF to addr 5, then next cycle read addr 5 on all ports -> every rdata=0xDEADBEEF and every rvalid=1 one cycle after the read.
REQ-025 In one cycle, we0: addr 7 = 0x11111111 and we1: addr 7 = 0x22222222 -> a later read of addr 7 returns 0x22222222.
REQ-026 Write 0x12345678 to addr 0 with ZERO_REG=1 -> a read of addr 0 returns 0x00000000.
REQ-027 Addr 9 holds 0xAAAAAAAA; write 0x55555555 to addr 9 while reading addr 9 in the same cycle -> rdata=0x55555555 with REGFILE_BYPASS_EN defined, 0xAAAAAAAA without it.
REQ-028 Fill all entries, pulse clr_req, assert reset at clear cycle 10 -> busy stays high 32 cycles after reset release; all entries read 0; writes issued during busy have no effect.
